// File: rtl/keypad_entry.sv
// Keypad input conditioning: synchronizes and debounces ten digit keys plus start/stop/clear,
// turns each accepted press into a one-cycle event and assembles a three-digit BCD cook time.
module keypad_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:9] switches,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    output logic       digit_valid,
    output logic [3:0] digit,
    output logic       start_pulse,
    output logic       stop_pulse,
    output logic       clear_pulse,
    output logic       key_error,
    output logic [3:0] entry_min,
    output logic [3:0] entry_tens,
    output logic [3:0] entry_sec,
    output logic [1:0] entry_count
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t      state, state_next;
    logic [12:0] raw_vec, sync1, sync2;
    logic [12:0] cap_vec, cap_next;
    logic [15:0] cnt, cnt_next;
    logic [16:0] cnt_inc;
    logic        at_limit;
    logic        accept_q, accept_next;
    logic        multi_key, is_digit;
    logic [3:0]  key_digit;

    // Bit 12 is digit 0 down to bit 3 for digit 9; then start, stop, clear (all active-high)
    assign raw_vec  = {switches, ~startn, ~stopn, ~clearn};
    assign cnt_inc  = {1'b0, cnt} + 17'd1;
    assign at_limit = (cnt_inc == 17'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            state    <= IDLE;
            cnt      <= '0;
            cap_vec  <= '0;
            accept_q <= 1'b0;
        end else begin
            sync1    <= raw_vec;
            sync2    <= sync1;
            state    <= state_next;
            cnt      <= cnt_next;
            cap_vec  <= cap_next;
            accept_q <= accept_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        cap_next    = cap_vec;
        accept_next = 1'b0;
        case (state)
            IDLE: begin
                if (sync2 != '0) begin
                    cap_next   = sync2;
                    cnt_next   = 16'd1;
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sync2 == '0) begin
                    state_next = IDLE;
                end else if (sync2 == cap_vec) begin
                    cnt_next = cnt_inc[15:0];
                    if (at_limit) begin
                        state_next  = HELD;
                        accept_next = 1'b1;
                    end
                end else begin
                    cap_next = sync2;
                    cnt_next = 16'd1;
                end
            end
            HELD: begin
                if (sync2 == '0) begin
                    cnt_next   = 16'd1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (sync2 != '0) begin
                    state_next = HELD;
                end else begin
                    cnt_next = cnt_inc[15:0];
                    if (at_limit) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // cap_vec is frozen in HELD, so it still holds the accepted key when accept_q is seen
    always_comb begin
        multi_key = ((cap_vec & (cap_vec - 13'd1)) != '0);
        is_digit  = |cap_vec[12:3];
        key_digit = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (cap_vec[12-i]) key_digit = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_valid <= 1'b0;
            digit       <= '0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            clear_pulse <= 1'b0;
            key_error   <= 1'b0;
            entry_min   <= '0;
            entry_tens  <= '0;
            entry_sec   <= '0;
            entry_count <= '0;
        end else begin
            digit_valid <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            clear_pulse <= 1'b0;
            key_error   <= 1'b0;
            if (accept_q) begin
                if (multi_key) begin
                    key_error <= 1'b1;
                end else if (is_digit) begin
                    if (entry_count == 2'd3) begin
                        key_error <= 1'b1;
                    end else begin
                        entry_min   <= entry_tens;
                        entry_tens  <= entry_sec;
                        entry_sec   <= key_digit;
                        entry_count <= entry_count + 2'd1;
                        digit       <= key_digit;
                        digit_valid <= 1'b1;
                    end
                end else if (cap_vec[2]) begin
                    start_pulse <= 1'b1;
                end else if (cap_vec[1]) begin
                    stop_pulse <= 1'b1;
                end else if (cap_vec[0]) begin
                    entry_min   <= '0;
                    entry_tens  <= '0;
                    entry_sec   <= '0;
                    entry_count <= '0;
                    clear_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: expected events are queued when keys are driven and
// matched against the DUT's pulses, entry state and timing; a second instance checks latency at 2.
module tb_keypad_entry;

    localparam int unsigned D  = 4;
    localparam int unsigned D2 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:9] sw;
    logic       startn, stopn, clearn;
    logic       digit_valid, start_pulse, stop_pulse, clear_pulse, key_error;
    logic [3:0] digit, entry_min, entry_tens, entry_sec;
    logic [1:0] entry_count;

    logic       stopn2;
    logic       digit_valid2, start_pulse2, stop_pulse2, clear_pulse2, key_error2;
    logic [3:0] digit2, entry_min2, entry_tens2, entry_sec2;
    logic [1:0] entry_count2;

    keypad_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .switches(sw), .startn(startn), .stopn(stopn), .clearn(clearn),
        .digit_valid(digit_valid), .digit(digit), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
        .clear_pulse(clear_pulse), .key_error(key_error), .entry_min(entry_min),
        .entry_tens(entry_tens), .entry_sec(entry_sec), .entry_count(entry_count)
    );

    keypad_entry #(.DEBOUNCE_CYCLES(D2)) dut2 (
        .clk(clk), .reset(reset), .switches(10'b0), .startn(1'b1), .stopn(stopn2), .clearn(1'b1),
        .digit_valid(digit_valid2), .digit(digit2), .start_pulse(start_pulse2),
        .stop_pulse(stop_pulse2), .clear_pulse(clear_pulse2), .key_error(key_error2),
        .entry_min(entry_min2), .entry_tens(entry_tens2), .entry_sec(entry_sec2),
        .entry_count(entry_count2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event codes: 1 digit, 2 start, 3 stop, 4 clear, 5 key_error, 7 simultaneous pulses
    typedef struct {
        logic [21:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [3:0] m_digit = '0, m_min = '0, m_tens = '0, m_sec = '0;
    logic [1:0] m_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] code, input int at);
        exp_t e;
        e.data = {code, m_digit, m_min, m_tens, m_sec, m_cnt};
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic expect_digit(input logic [3:0] d, input int at);
        if (m_cnt < 2'd3) begin
            m_min   = m_tens;
            m_tens  = m_sec;
            m_sec   = d;
            m_cnt   = m_cnt + 2'd1;
            m_digit = d;
            push(4'd1, at);
        end else begin
            push(4'd5, at);
        end
    endtask

    task automatic drive(input logic [0:9] s, input logic st, input logic sp, input logic cl,
                         output int e);
        @(posedge clk);
        #1;
        sw     = s;
        startn = ~st;
        stopn  = ~sp;
        clearn = ~cl;
        e      = cyc + 1;
    endtask

    logic [3:0] mon_code;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (!reset && (digit_valid | start_pulse | stop_pulse | clear_pulse | key_error)) begin
            if ($countones({digit_valid, start_pulse, stop_pulse, clear_pulse, key_error}) > 1)
                mon_code = 4'd7;
            else if (digit_valid) mon_code = 4'd1;
            else if (start_pulse) mon_code = 4'd2;
            else if (stop_pulse)  mon_code = 4'd3;
            else if (clear_pulse) mon_code = 4'd4;
            else                  mon_code = 4'd5;
            if (sb.size() == 0) begin
                check("unexpected_event", {28'd0, mon_code}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("event", {mon_code, digit, entry_min, entry_tens, entry_sec, entry_count},
                      mon_e.data);
                if (mon_e.at >= 0) check("event_cycle", cyc, mon_e.at);
            end
        end
    end

    function automatic logic [0:9] key(input int d);
        logic [0:9] k;
        k = '0;
        k[d] = 1'b1;
        return k;
    endfunction

    int e;
    int dig_seq[3] = '{1, 3, 0};

    initial begin
        reset  = 1'b1;
        sw     = '0;
        startn = 1'b1;
        stopn  = 1'b1;
        clearn = 1'b1;
        stopn2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {digit_valid, digit, start_pulse, stop_pulse, clear_pulse, key_error,
              entry_min, entry_tens, entry_sec, entry_count}, 32'd0);
        #1 reset = 1'b0;

        // Reset in the middle of a press discards it
        drive(key(5), 1'b0, 1'b0, 1'b0, e);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_mid_press", {digit_valid, digit, start_pulse, stop_pulse, clear_pulse,
              key_error, entry_min, entry_tens, entry_sec, entry_count}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 sw = '0;
        repeat (12) @(negedge clk);
        check("no_event_after_reset", {digit_valid, digit, start_pulse, stop_pulse, clear_pulse,
              key_error, entry_min, entry_tens, entry_sec, entry_count}, 32'd0);

        // Digit entry 1, 3, 0
        foreach (dig_seq[i]) begin
            drive(key(dig_seq[i]), 1'b0, 1'b0, 1'b0, e);
            expect_digit(4'(dig_seq[i]), e + D + 2);
            repeat (10) @(posedge clk);
            drive('0, 1'b0, 1'b0, 1'b0, e);
            repeat (10) @(posedge clk);
        end
        @(negedge clk);
        check("entry_after_130", {entry_min, entry_tens, entry_sec, entry_count},
              {4'd1, 4'd3, 4'd0, 2'd3});

        // Overflow: digit into a full entry
        drive(key(7), 1'b0, 1'b0, 1'b0, e);
        expect_digit(4'd7, e + D + 2);
        repeat (10) @(posedge clk);
        drive('0, 1'b0, 1'b0, 1'b0, e);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("entry_after_overflow", {entry_min, entry_tens, entry_sec, entry_count},
              {4'd1, 4'd3, 4'd0, 2'd3});

        // Clear
        drive('0, 1'b0, 1'b0, 1'b1, e);
        m_min = '0; m_tens = '0; m_sec = '0; m_cnt = '0;
        push(4'd4, e + D + 2);
        repeat (10) @(posedge clk);
        drive('0, 1'b0, 1'b0, 1'b0, e);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("entry_after_clear", {entry_min, entry_tens, entry_sec, entry_count}, 32'd0);

        // Bounce on key 4, then a stable hold
        repeat (3) begin
            drive(key(4), 1'b0, 1'b0, 1'b0, e);
            drive('0, 1'b0, 1'b0, 1'b0, e);
        end
        drive(key(4), 1'b0, 1'b0, 1'b0, e);
        expect_digit(4'd4, e + D + 2);
        repeat (10) @(posedge clk);
        drive('0, 1'b0, 1'b0, 1'b0, e);
        repeat (10) @(posedge clk);

        // Two keys at once, then a long start hold
        drive(key(2), 1'b1, 1'b0, 1'b0, e);
        push(4'd5, e + D + 2);
        repeat (10) @(posedge clk);
        drive('0, 1'b0, 1'b0, 1'b0, e);
        repeat (10) @(posedge clk);
        drive('0, 1'b1, 1'b0, 1'b0, e);
        push(4'd2, e + D + 2);
        repeat (40) @(posedge clk);
        drive('0, 1'b0, 1'b0, 1'b0, e);
        repeat (10) @(posedge clk);

        // Stop on the main instance
        drive('0, 1'b0, 1'b1, 1'b0, e);
        push(4'd3, e + D + 2);
        repeat (10) @(posedge clk);
        drive('0, 1'b0, 1'b0, 1'b0, e);
        repeat (10) @(posedge clk);

        // Latency with DEBOUNCE_CYCLES = 2: stop pulse only in cycle E+4
        @(posedge clk);
        #1 stopn2 = 1'b0;
        e = cyc + 1;
        repeat (8) begin
            @(negedge clk);
            check("lat2_stop_pulse", {31'd0, stop_pulse2}, {31'd0, (cyc == e + 4)});
        end
        #1 stopn2 = 1'b1;

        repeat (20) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        check("final_entry", {entry_min, entry_tens, entry_sec, entry_count, digit},
              {m_min, m_tens, m_sec, m_cnt, m_digit});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
